// File: rtl/multi_acc_datapath.sv
// ----------------------------------------------------------------------------
// multi_acc_datapath
//
// Purpose:
//   Small accumulator machine with N_ACC accumulators. It accepts one
//   instruction at a time (NOP, LD, ADD, SUB, ST). An operand is either a
//   sign-extended immediate or a word read from data memory. Memory reads wait
//   up to MEM_TIMEOUT cycles for read data. If no data arrives in that time,
//   the instruction is dropped and a sticky error is raised.
//
// Optional feature:
//   MULTI_ACC_SATURATE_EN - when defined, an ADD/SUB that overflows writes the
//   most positive or most negative value instead of the wrapped result.
//   Flags are the same in both builds.
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_valid        instruction offered
//   o_ready        block is IDLE and accepts an instruction
//   i_opcode       000 NOP, 001 LD, 010 ADD, 011 SUB, 100 ST, others ignored
//   i_acc_sel      target accumulator
//   i_src          0 = memory operand, 1 = sign-extended immediate
//   i_operand      memory address or immediate
//   o_dm_addr      data-memory address (registered operand)
//   o_dm_rd_req    read request, high while waiting for read data
//   i_dm_rd_valid  read data valid (honoured only while waiting)
//   i_dm_rd_data   read data
//   o_dm_wr_en     write strobe (ST, execute cycle)
//   o_dm_wr_data   write data (selected accumulator)
//   o_acc          accumulator chosen by the last accepted select
//   o_flags        {N, Z, C, V}
//   o_done         one-cycle completion pulse
//   o_err          sticky memory-timeout error, cleared on the next accept
//   o_dbg_state    current FSM state (debug)
//
// Handshake: an instruction transfers on a rising edge where i_valid and
// o_ready are both 1. o_ready is high only in IDLE and does not depend on
// i_valid. A source may hold or withdraw i_valid freely while o_ready is low.
// ----------------------------------------------------------------------------
module multi_acc_datapath #(
    parameter int NB_DATA     = 16,
    parameter int NB_DATA_IN  = 11,
    parameter int N_ACC       = 4,
    parameter int NB_SEL      = $clog2(N_ACC),
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_opcode,
    input  logic [NB_SEL-1:0]     i_acc_sel,
    input  logic                  i_src,
    input  logic [NB_DATA_IN-1:0] i_operand,
    output logic [NB_DATA_IN-1:0] o_dm_addr,
    output logic                  o_dm_rd_req,
    input  logic                  i_dm_rd_valid,
    input  logic [NB_DATA-1:0]    i_dm_rd_data,
    output logic                  o_dm_wr_en,
    output logic [NB_DATA-1:0]    o_dm_wr_data,
    output logic [NB_DATA-1:0]    o_acc,
    output logic [3:0]            o_flags,
    output logic                  o_done,
    output logic                  o_err,
    output logic [1:0]            o_dbg_state
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LD  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_ST  = 3'b100;

    localparam int MSB = NB_DATA - 1;

    // The wait counter is 8 bits because MEM_TIMEOUT is at most 255.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    localparam logic [NB_DATA-1:0] SAT_MAX = {1'b0, {(NB_DATA-1){1'b1}}};
    localparam logic [NB_DATA-1:0] SAT_MIN = {1'b1, {(NB_DATA-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_EXEC     = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Registered instruction fields
    logic [2:0]            opcode_q;
    logic [NB_SEL-1:0]     sel_q;
    logic                  src_q;
    logic [NB_DATA_IN-1:0] operand_q;
    logic [NB_DATA-1:0]    mem_data_q;
    logic [7:0]            wait_cnt_q;

    // Architectural state
    logic [NB_DATA-1:0]    acc_q [N_ACC];
    logic [3:0]            flags_q;
    logic                  done_q;
    logic                  err_q;

    // FSM outputs / strobes
    logic accept;
    logic mem_op;
    logic rd_latch;
    logic timeout;
    logic ready;
    logic rd_req;
    logic wr_en;

    // ALU signals
    logic [NB_DATA-1:0] imm_ext;
    logic [NB_DATA-1:0] operand_val;
    logic [NB_DATA-1:0] acc_cur;
    logic [NB_DATA:0]   add_full;
    logic [NB_DATA:0]   sub_full;
    logic [NB_DATA-1:0] raw;
    logic [NB_DATA-1:0] result;
    logic               alu_c;
    logic               alu_v;
    logic               is_arith;
    logic               acc_we;
    logic               flags_we;
    logic [3:0]         flags_new;

    // Only LD/ADD/SUB with a memory source need a read. ST with i_src=0 does not.
    assign mem_op = ((i_opcode == OP_LD) || (i_opcode == OP_ADD) ||
                     (i_opcode == OP_SUB)) && !i_src;
    assign accept = i_valid && (state_q == ST_IDLE);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ready    = 1'b0;
        rd_req   = 1'b0;
        wr_en    = 1'b0;
        rd_latch = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (i_valid) begin
                    state_d = mem_op ? ST_MEM_WAIT : ST_EXEC;
                end
            end
            ST_MEM_WAIT: begin
                rd_req = 1'b1;
                // Valid wins over timeout, including in the last allowed cycle.
                if (i_dm_rd_valid) begin
                    rd_latch = 1'b1;
                    state_d  = ST_EXEC;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                wr_en   = (opcode_q == OP_ST);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    assign imm_ext     = {{(NB_DATA-NB_DATA_IN){operand_q[NB_DATA_IN-1]}}, operand_q};
    assign operand_val = src_q ? imm_ext : mem_data_q;
    assign acc_cur     = acc_q[sel_q];
    assign add_full    = {1'b0, acc_cur} + {1'b0, operand_val};
    // Bit NB_DATA of the zero-extended difference is the unsigned borrow.
    assign sub_full    = {1'b0, acc_cur} - {1'b0, operand_val};

    always_comb begin
        raw       = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        is_arith  = 1'b0;
        acc_we    = 1'b0;
        flags_we  = 1'b0;
        flags_new = flags_q;
        result    = operand_val;
        case (opcode_q)
            OP_LD: begin
                acc_we    = 1'b1;
                flags_we  = 1'b1;
                flags_new = {operand_val[MSB], (operand_val == '0), 2'b00};
            end
            OP_ADD: begin
                is_arith = 1'b1;
                raw      = add_full[NB_DATA-1:0];
                alu_c    = add_full[NB_DATA];
                alu_v    = (acc_cur[MSB] == operand_val[MSB]) && (raw[MSB] != acc_cur[MSB]);
            end
            OP_SUB: begin
                is_arith = 1'b1;
                raw      = sub_full[NB_DATA-1:0];
                alu_c    = sub_full[NB_DATA];
                alu_v    = (acc_cur[MSB] != operand_val[MSB]) && (raw[MSB] != acc_cur[MSB]);
            end
            default: begin
            end
        endcase

        if (is_arith) begin
            acc_we    = 1'b1;
            flags_we  = 1'b1;
            // Flags always come from the wrapped result.
            flags_new = {raw[MSB], (raw == '0), alu_c, alu_v};
`ifdef MULTI_ACC_SATURATE_EN
            // On overflow the true result has the sign of the accumulator.
            if (alu_v) begin
                result = acc_cur[MSB] ? SAT_MIN : SAT_MAX;
            end else begin
                result = raw;
            end
`else
            result = raw;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            opcode_q   <= OP_NOP;
            sel_q      <= '0;
            src_q      <= 1'b0;
            operand_q  <= '0;
            mem_data_q <= '0;
            wait_cnt_q <= '0;
            flags_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < N_ACC; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            done_q <= (state_q == ST_EXEC) || timeout;

            if (accept) begin
                opcode_q   <= i_opcode;
                sel_q      <= i_acc_sel;
                src_q      <= i_src;
                operand_q  <= i_operand;
                wait_cnt_q <= '0;
                err_q      <= 1'b0;
            end

            if ((state_q == ST_MEM_WAIT) && !i_dm_rd_valid && !timeout) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end

            if (rd_latch) begin
                mem_data_q <= i_dm_rd_data;
            end

            if (timeout) begin
                err_q <= 1'b1;
            end

            if ((state_q == ST_EXEC) && acc_we) begin
                acc_q[sel_q] <= result;
            end

            if ((state_q == ST_EXEC) && flags_we) begin
                flags_q <= flags_new;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_ready      = ready;
    assign o_dm_rd_req  = rd_req;
    assign o_dm_wr_en   = wr_en;
    assign o_dm_addr    = operand_q;
    assign o_dm_wr_data = acc_cur;
    assign o_acc        = acc_cur;
    assign o_flags      = flags_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_multi_acc_datapath.sv
// ----------------------------------------------------------------------------
// tb_multi_acc_datapath
//
// Directed bench for multi_acc_datapath with default parameters. Latencies
// are counted in falling edges after the accept edge. An immediate
// instruction therefore shows o_done at count 2. A memory instruction whose
// read data arrives in MEM_WAIT cycle m shows o_done at count m + 2.
// ----------------------------------------------------------------------------
module tb_multi_acc_datapath;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LD  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_ST  = 3'b100;

    logic        clk;
    logic        i_reset;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_opcode;
    logic [1:0]  i_acc_sel;
    logic        i_src;
    logic [10:0] i_operand;
    logic [10:0] o_dm_addr;
    logic        o_dm_rd_req;
    logic        i_dm_rd_valid;
    logic [15:0] i_dm_rd_data;
    logic        o_dm_wr_en;
    logic [15:0] o_dm_wr_data;
    logic [15:0] o_acc;
    logic [3:0]  o_flags;
    logic        o_done;
    logic        o_err;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int errors = 0;

    // Results gathered by run_op
    int          lat;
    int          rd_n;
    int          wr_n;
    logic [15:0] wr_data;
    logic [10:0] wr_addr;
    logic [10:0] rd_addr;
    logic        err_d;

    multi_acc_datapath dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_opcode     (i_opcode),
        .i_acc_sel    (i_acc_sel),
        .i_src        (i_src),
        .i_operand    (i_operand),
        .o_dm_addr    (o_dm_addr),
        .o_dm_rd_req  (o_dm_rd_req),
        .i_dm_rd_valid(i_dm_rd_valid),
        .i_dm_rd_data (i_dm_rd_data),
        .o_dm_wr_en   (o_dm_wr_en),
        .o_dm_wr_data (o_dm_wr_data),
        .o_acc        (o_acc),
        .o_flags      (o_flags),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        i_reset = 1'b0;
        repeat (2) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    // Offers one instruction. The task returns #1 after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [1:0] sel,
                         input logic src, input logic [10:0] operand);
        @(negedge clk);
        i_valid   = 1'b1;
        i_opcode  = op;
        i_acc_sel = sel;
        i_src     = src;
        i_operand = operand;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Issues an instruction and waits, with a bound, for o_done. If valid_at > 0,
    // read data is supplied in that cycle after accept. If valid_at == 0, the
    // read-valid input is left as it is.
    task automatic run_op(input logic [2:0] op, input logic [1:0] sel,
                          input logic src, input logic [10:0] operand,
                          input int valid_at, input logic [15:0] rdata,
                          output int o_lat, output int o_rd_n, output int o_wr_n,
                          output logic [15:0] o_wr_data, output logic [10:0] o_wr_addr,
                          output logic [10:0] o_rd_addr, output logic o_err_d);
        o_lat = -1; o_rd_n = 0; o_wr_n = 0;
        o_wr_data = '0; o_wr_addr = '0; o_rd_addr = '0; o_err_d = 1'b0;
        issue(op, sel, src, operand);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (o_dm_rd_req) begin o_rd_n++; o_rd_addr = o_dm_addr; end
            if (o_dm_wr_en) begin o_wr_n++; o_wr_data = o_dm_wr_data; o_wr_addr = o_dm_addr; end
            if (o_done) begin o_lat = n; o_err_d = o_err; break; end
            if (valid_at > 0) begin
                i_dm_rd_valid = (n == valid_at);
                i_dm_rd_data  = (n == valid_at) ? rdata : 16'h0000;
            end
        end
        if (valid_at > 0) i_dm_rd_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", o_ready); end
        checks++; if (o_acc !== 16'h0000) begin errors++; $display("FAIL reset_acc: got %h exp 0000", o_acc); end
        checks++; if (o_flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b exp 0000", o_flags); end
        checks++; if ({o_dm_rd_req, o_dm_wr_en, o_done, o_err} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b exp 0000", {o_dm_rd_req, o_dm_wr_en, o_done, o_err}); end
        i_reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ld_imm();
        // 0x7FF is -1 in 11 bits, so it sign-extends to 0xFFFF.
        run_op(OP_LD, 2'd1, 1'b1, 11'h7FF, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if (lat !== 2) begin errors++; $display("FAIL ld_imm_latency: got %0d exp 2", lat); end
        checks++; if (o_acc !== 16'hFFFF) begin errors++; $display("FAIL ld_imm_acc: got %h exp FFFF", o_acc); end
        checks++; if (o_flags !== 4'b1000) begin errors++; $display("FAIL ld_imm_flags: got %b exp 1000", o_flags); end
        checks++; if (rd_n !== 0) begin errors++; $display("FAIL ld_imm_no_read: got %0d exp 0", rd_n); end
        run_op(OP_LD, 2'd1, 1'b1, 11'h000, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if ({o_acc, o_flags} !== {16'h0000, 4'b0100}) begin errors++; $display("FAIL ld_zero: got %h/%b exp 0000/0100", o_acc, o_flags); end
    endtask

    task automatic test_add_overflow();
        logic [15:0] exp_acc;
        run_op(OP_LD, 2'd0, 1'b0, 11'h007, 1, 16'h7FFF, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if (lat !== 3) begin errors++; $display("FAIL ld_mem_first_cycle_latency: got %0d exp 3", lat); end
        checks++; if (rd_n !== 1) begin errors++; $display("FAIL ld_mem_first_cycle_rdreq: got %0d exp 1", rd_n); end
        checks++; if ({o_acc, o_flags} !== {16'h7FFF, 4'b0000}) begin errors++; $display("FAIL ld_mem_value: got %h/%b exp 7FFF/0000", o_acc, o_flags); end
`ifdef MULTI_ACC_SATURATE_EN
        exp_acc = 16'h7FFF;
`else
        exp_acc = 16'h8000;
`endif
        run_op(OP_ADD, 2'd0, 1'b1, 11'h001, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if (lat !== 2) begin errors++; $display("FAIL add_ovf_latency: got %0d exp 2", lat); end
        checks++; if (o_acc !== exp_acc) begin errors++; $display("FAIL add_ovf_acc: got %h exp %h", o_acc, exp_acc); end
        checks++; if (o_flags !== 4'b1001) begin errors++; $display("FAIL add_ovf_flags: got %b exp 1001", o_flags); end
    endtask

    task automatic test_sub_carry();
        run_op(OP_LD, 2'd3, 1'b1, 11'h005, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        run_op(OP_SUB, 2'd3, 1'b1, 11'h006, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if ({o_acc, o_flags} !== {16'hFFFF, 4'b1010}) begin errors++; $display("FAIL sub_borrow: got %h/%b exp FFFF/1010", o_acc, o_flags); end
        run_op(OP_SUB, 2'd3, 1'b1, 11'h7FF, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if ({o_acc, o_flags} !== {16'h0000, 4'b0100}) begin errors++; $display("FAIL sub_zero: got %h/%b exp 0000/0100", o_acc, o_flags); end
        run_op(OP_ADD, 2'd3, 1'b1, 11'h7FF, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if ({o_acc, o_flags} !== {16'hFFFF, 4'b1000}) begin errors++; $display("FAIL add_neg: got %h/%b exp FFFF/1000", o_acc, o_flags); end
        run_op(OP_ADD, 2'd3, 1'b1, 11'h001, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if ({o_acc, o_flags} !== {16'h0000, 4'b0110}) begin errors++; $display("FAIL add_carry: got %h/%b exp 0000/0110", o_acc, o_flags); end
    endtask

    task automatic test_add_mem();
        run_op(OP_LD, 2'd2, 1'b1, 11'h020, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        // Data arrives in the third MEM_WAIT cycle. o_done follows five cycles
        // after the accept cycle, which is the sixth cycle counting the accept
        // cycle as the first.
        run_op(OP_ADD, 2'd2, 1'b0, 11'h005, 3, 16'h0010, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if (rd_n !== 3) begin errors++; $display("FAIL add_mem_rdreq_cycles: got %0d exp 3", rd_n); end
        checks++; if (rd_addr !== 11'h005) begin errors++; $display("FAIL add_mem_addr: got %h exp 005", rd_addr); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL add_mem_latency: got %0d exp 5", lat); end
        checks++; if ({o_acc, o_flags} !== {16'h0030, 4'b0000}) begin errors++; $display("FAIL add_mem_acc: got %h/%b exp 0030/0000", o_acc, o_flags); end
    endtask

    task automatic test_timeout();
        i_dm_rd_valid = 1'b0;
        run_op(OP_LD, 2'd2, 1'b1, 11'h7F0, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        run_op(OP_LD, 2'd2, 1'b0, 11'h009, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if (rd_n !== 15) begin errors++; $display("FAIL timeout_rdreq_cycles: got %0d exp 15", rd_n); end
        checks++; if (lat !== 16) begin errors++; $display("FAIL timeout_done: got %0d exp 16", lat); end
        checks++; if (err_d !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b exp 1", err_d); end
        checks++; if ({o_acc, o_flags} !== {16'hFFF0, 4'b1000}) begin errors++; $display("FAIL timeout_unchanged: got %h/%b exp FFF0/1000", o_acc, o_flags); end
        repeat (2) @(negedge clk);
        checks++; if ({o_err, o_done, o_ready} !== 3'b101) begin errors++; $display("FAIL err_sticky: got %b exp 101", {o_err, o_done, o_ready}); end
        run_op(OP_NOP, 2'd2, 1'b1, 11'h000, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if (err_d !== 1'b0) begin errors++; $display("FAIL err_clear: got %b exp 0", err_d); end
        checks++; if ({o_acc, o_flags} !== {16'hFFF0, 4'b1000}) begin errors++; $display("FAIL nop_unchanged: got %h/%b exp FFF0/1000", o_acc, o_flags); end
    endtask

    task automatic test_store();
        run_op(OP_LD, 2'd2, 1'b0, 11'h011, 2, 16'h1234, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if ({lat, o_acc} !== {32'd4, 16'h1234}) begin errors++; $display("FAIL st_prep: got lat %0d acc %h exp 4 1234", lat, o_acc); end
        run_op(OP_ST, 2'd2, 1'b1, 11'h03A, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if (wr_n !== 1) begin errors++; $display("FAIL st_strobe_cycles: got %0d exp 1", wr_n); end
        checks++; if ({wr_data, wr_addr} !== {16'h1234, 11'h03A}) begin errors++; $display("FAIL st_data_addr: got %h/%h exp 1234/03A", wr_data, wr_addr); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL st_latency: got %0d exp 2", lat); end
        checks++; if ({o_acc, o_flags} !== {16'h1234, 4'b0000}) begin errors++; $display("FAIL st_unchanged: got %h/%b exp 1234/0000", o_acc, o_flags); end
    endtask

    task automatic test_reset_abort();
        int strobes;
        // Reset during EXEC of a store
        issue(OP_ST, 2'd2, 1'b1, 11'h03B);
        checks++; if ({o_ready, o_dm_wr_en} !== 2'b01) begin errors++; $display("FAIL exec_wr_en: got %b exp 01", {o_ready, o_dm_wr_en}); end
        i_reset = 1'b0;
        #1;
        checks++; if ({o_dm_wr_en, o_ready, o_acc} !== {1'b0, 1'b1, 16'h0000}) begin errors++; $display("FAIL reset_exec_abort: got %b %b %h exp 0 1 0000", o_dm_wr_en, o_ready, o_acc); end
        @(negedge clk);
        i_reset = 1'b1;
        strobes = 0;
        repeat (3) begin @(negedge clk); strobes += int'(o_dm_wr_en) + int'(o_done); end
        checks++; if (strobes !== 0) begin errors++; $display("FAIL reset_exec_quiet: got %0d exp 0", strobes); end
        // Reset during MEM_WAIT of a load; later read-valid must be ignored
        issue(OP_LD, 2'd1, 1'b0, 11'h00C);
        @(negedge clk);
        checks++; if ({o_dm_rd_req, o_dm_addr} !== {1'b1, 11'h00C}) begin errors++; $display("FAIL memwait_req: got %b/%h exp 1/00C", o_dm_rd_req, o_dm_addr); end
        i_reset = 1'b0;
        #1;
        checks++; if ({o_dm_rd_req, o_ready, o_flags} !== {1'b0, 1'b1, 4'b0000}) begin errors++; $display("FAIL reset_memwait_abort: got %b %b %b exp 0 1 0000", o_dm_rd_req, o_ready, o_flags); end
        @(negedge clk);
        i_reset = 1'b1;
        i_dm_rd_valid = 1'b1;
        i_dm_rd_data  = 16'h5555;
        strobes = 0;
        repeat (3) begin @(negedge clk); strobes += int'(o_done) + int'(o_dm_rd_req); end
        i_dm_rd_valid = 1'b0;
        checks++; if ({strobes, o_acc} !== {32'd0, 16'h0000}) begin errors++; $display("FAIL reset_memwait_quiet: got %0d/%h exp 0/0000", strobes, o_acc); end
    endtask

    task automatic test_sel_isolation();
        logic [15:0] exp_acc [4];
        exp_acc[0] = 16'h0001; exp_acc[1] = 16'h0012; exp_acc[2] = 16'h0003; exp_acc[3] = 16'h0004;
        for (int k = 0; k < 4; k++) begin
            run_op(OP_LD, 2'(k), 1'b1, 11'(k + 1), 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        end
        run_op(OP_ADD, 2'd1, 1'b1, 11'h010, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        for (int k = 0; k < 4; k++) begin
            run_op(OP_NOP, 2'(k), 1'b1, 11'h000, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
            checks++; if (o_acc !== exp_acc[k]) begin errors++; $display("FAIL sel_isolation_acc%0d: got %h exp %h", k, o_acc, exp_acc[k]); end
        end
    endtask

    task automatic test_illegal_nop();
        run_op(OP_LD, 2'd3, 1'b1, 11'h400, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if ({o_acc, o_flags} !== {16'hFC00, 4'b1000}) begin errors++; $display("FAIL ld_fc00: got %h/%b exp FC00/1000", o_acc, o_flags); end
        run_op(3'b101, 2'd3, 1'b0, 11'h012, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if ({lat, rd_n, wr_n} !== {32'd2, 32'd0, 32'd0}) begin errors++; $display("FAIL illegal_timing: got lat %0d rd %0d wr %0d exp 2 0 0", lat, rd_n, wr_n); end
        checks++; if ({o_acc, o_flags} !== {16'hFC00, 4'b1000}) begin errors++; $display("FAIL illegal_unchanged: got %h/%b exp FC00/1000", o_acc, o_flags); end
        run_op(3'b111, 2'd3, 1'b1, 11'h001, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if ({o_acc, o_flags} !== {16'hFC00, 4'b1000}) begin errors++; $display("FAIL illegal7_unchanged: got %h/%b exp FC00/1000", o_acc, o_flags); end
        run_op(OP_ST, 2'd3, 1'b0, 11'h055, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if ({lat, rd_n, wr_n} !== {32'd2, 32'd0, 32'd1}) begin errors++; $display("FAIL st_mem_src_timing: got lat %0d rd %0d wr %0d exp 2 0 1", lat, rd_n, wr_n); end
        checks++; if ({wr_data, wr_addr} !== {16'hFC00, 11'h055}) begin errors++; $display("FAIL st_mem_src_data: got %h/%h exp FC00/055", wr_data, wr_addr); end
    endtask

    task automatic test_ignore_valid();
        i_dm_rd_valid = 1'b1;
        i_dm_rd_data  = 16'hAAAA;
        run_op(OP_ADD, 2'd0, 1'b1, 11'h002, 0, 16'h0, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if ({lat, o_acc, o_flags} !== {32'd2, 16'h0003, 4'b0000}) begin errors++; $display("FAIL stray_valid: got lat %0d acc %h flags %b exp 2 0003 0000", lat, o_acc, o_flags); end
        run_op(OP_LD, 2'd0, 1'b0, 11'h020, 1, 16'h0042, lat, rd_n, wr_n, wr_data, wr_addr, rd_addr, err_d);
        checks++; if ({lat, o_acc} !== {32'd3, 16'h0042}) begin errors++; $display("FAIL ld_mem_after_stray: got lat %0d acc %h exp 3 0042", lat, o_acc); end
        i_dm_rd_valid = 1'b0;
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        i_reset = 1'b0; i_valid = 1'b0; i_opcode = OP_NOP; i_acc_sel = 2'd0;
        i_src = 1'b1; i_operand = '0; i_dm_rd_valid = 1'b0; i_dm_rd_data = '0;
        test_reset();
        test_ld_imm();
        test_add_overflow();
        test_sub_carry();
        test_add_mem();
        test_timeout();
        test_store();
        test_reset_abort();
        test_sel_isolation();
        test_illegal_nop();
        test_ignore_valid();
        apply_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
